// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a synchronous byte FIFO.
// The bit period is chosen from Baud_Set and latched when a byte is popped.
module uart_tx_fifo #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [2:0]                  Baud_Set,
    input  logic                        wr_en,
    input  logic [7:0]                  wr_data,
    output logic                        full,
    output logic                        empty,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        overflow,
    output logic                        tx,
    output logic                        tx_busy,
    output logic                        tx_done
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int DW = $clog2(CLK_FREQ / 9600 + 1);

    localparam logic [DW-1:0] DIV_9600   = DW'(CLK_FREQ / 9600);
    localparam logic [DW-1:0] DIV_19200  = DW'(CLK_FREQ / 19200);
    localparam logic [DW-1:0] DIV_38400  = DW'(CLK_FREQ / 38400);
    localparam logic [DW-1:0] DIV_57600  = DW'(CLK_FREQ / 57600);
    localparam logic [DW-1:0] DIV_115200 = DW'(CLK_FREQ / 115200);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // Unused select codes fall back to the fastest rate.
    function automatic logic [DW-1:0] div_sel(input logic [2:0] sel);
        logic [DW-1:0] d;
        case (sel)
            3'd0:    d = DIV_9600;
            3'd1:    d = DIV_19200;
            3'd2:    d = DIV_38400;
            3'd3:    d = DIV_57600;
            default: d = DIV_115200;
        endcase
        return d;
    endfunction

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          r_full;
    logic          r_empty;
    logic          r_overflow;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [DW-1:0] r_baud_cnt;
    logic [DW-1:0] r_div;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_shift;
    logic          r_tx;
    logic          r_busy;
    logic          r_done;

    logic          w_push;
    logic          w_pop;
    logic          w_bit_end;
    logic [CW-1:0] w_count_nxt;

    // Full is the pre-edge flag, so a write into a full FIFO is dropped even when a pop happens.
    always_comb begin
        w_push      = wr_en & ~r_full;
        w_bit_end   = (r_baud_cnt == (r_div - DW'(1)));
        w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
    end

    // Next-state and pop decision; a byte written this cycle is only visible next cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!r_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_START;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state_nxt = S_DATA;
                end else begin
                    w_state_nxt = S_START;
                end
            end
            S_DATA: begin
                if (w_bit_end && (r_bit_idx == 3'd7)) begin
                    w_state_nxt = S_STOP;
                end else begin
                    w_state_nxt = S_DATA;
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_STOP;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // FIFO storage; contents need no reset because occupancy is tracked separately.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= wr_data;
        end
    end

    // FIFO pointers, occupancy and status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr     <= AW'(0);
            r_rptr     <= AW'(0);
            r_count    <= CW'(0);
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            r_count    <= w_count_nxt;
            r_full     <= (w_count_nxt == CW'(FIFO_DEPTH));
            r_empty    <= (w_count_nxt == CW'(0));
            r_overflow <= r_overflow | (wr_en & r_full);
        end
    end

    // Transmit sequencer; line outputs are registered from the current state, one cycle behind it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_baud_cnt <= DW'(0);
            r_div      <= DIV_115200;
            r_bit_idx  <= 3'd0;
            r_shift    <= 8'd0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == S_IDLE) || w_bit_end) begin
                r_baud_cnt <= DW'(0);
            end else begin
                r_baud_cnt <= r_baud_cnt + DW'(1);
            end
            if (w_pop) begin
                r_div   <= div_sel(Baud_Set);
                r_shift <= r_mem[r_rptr];
            end else if ((r_state == S_DATA) && w_bit_end) begin
                r_shift <= {1'b0, r_shift[7:1]};
            end
            if (r_state != S_DATA) begin
                r_bit_idx <= 3'd0;
            end else if (w_bit_end) begin
                r_bit_idx <= r_bit_idx + 3'd1;
            end
            case (r_state)
                S_START: r_tx <= 1'b0;
                S_DATA:  r_tx <= r_shift[0];
                default: r_tx <= 1'b1;
            endcase
            r_busy <= (r_state != S_IDLE);
            r_done <= (r_state == S_STOP) && w_bit_end;
        end
    end

    assign full       = r_full;
    assign empty      = r_empty;
    assign fifo_count = r_count;
    assign overflow   = r_overflow;
    assign tx         = r_tx;
    assign tx_busy    = r_busy;
    assign tx_done    = r_done;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: every cycle the outputs are compared
// with a frame-level reference model driven by the same randomized stimulus.
module tb_uart_tx_fifo;
    localparam int DEPTH = 8;

    logic       clk     = 1'b0;
    logic       rst     = 1'b1;
    logic [2:0] baud    = 3'd4;
    logic       wr_en   = 1'b0;
    logic [7:0] wr_data = 8'd0;
    logic       full, empty, overflow, tx, tx_busy, tx_done;
    logic [3:0] fifo_count;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit rand_baud = 1'b0;

    // Reference model: queue of pending bytes plus the most recently started frame.
    logic [7:0] m_q[$];
    int         m_cnt      = 0;
    bit         m_ovf      = 1'b0;
    int         m_next_pop = 0;
    bit         m_fv       = 1'b0;
    int         m_fs       = 0;
    int         m_fdiv     = 1;
    logic [7:0] m_fb       = 8'd0;
    bit         m_pop;
    bit         m_acc;

    uart_tx_fifo #(.CLK_FREQ(50_000_000), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .Baud_Set   (baud),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .full       (full),
        .empty      (empty),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .tx         (tx),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
            if (errors >= 40) begin
                $display("Result: errors=%0d of %0d checks", errors, checks);
                $finish;
            end
        end
    endtask

    function automatic int exp_div(input logic [2:0] s);
        case (s)
            3'd0:    return 5208;
            3'd1:    return 2604;
            3'd2:    return 1302;
            3'd3:    return 868;
            default: return 434;
        endcase
    endfunction

    // Expected {tx, busy, done, full, empty, overflow, count} for the current cycle.
    function automatic logic [31:0] status_exp();
        logic etx, ebusy, edone;
        int   k;
        etx   = 1'b1;
        ebusy = 1'b0;
        edone = 1'b0;
        if (rst) begin
            return {22'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0};
        end
        if (m_fv && (cyc >= m_fs) && (cyc < m_fs + 10 * m_fdiv)) begin
            k     = (cyc - m_fs) / m_fdiv;
            ebusy = 1'b1;
            edone = (cyc == m_fs + 10 * m_fdiv - 1);
            if (k == 0) begin
                etx = 1'b0;
            end else if (k == 9) begin
                etx = 1'b1;
            end else begin
                etx = m_fb[k-1];
            end
        end
        return {22'd0, etx, ebusy, edone, (m_cnt == DEPTH), (m_cnt == 0), m_ovf, 4'(m_cnt)};
    endfunction

    // Model update on each rising edge using the pre-edge inputs.
    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            if (rst) begin
                m_q.delete();
                m_cnt      = 0;
                m_ovf      = 1'b0;
                m_next_pop = 0;
                m_fv       = 1'b0;
            end else begin
                m_pop = (m_cnt > 0) && (cyc >= m_next_pop);
                m_acc = wr_en && (m_cnt < DEPTH);
                if (wr_en && (m_cnt == DEPTH)) m_ovf = 1'b1;
                if (m_pop) begin
                    m_fb       = m_q.pop_front();
                    m_fdiv     = exp_div(baud);
                    m_fs       = cyc + 1;
                    m_fv       = 1'b1;
                    m_next_pop = cyc + 10 * m_fdiv + 1;
                end
                if (m_acc) m_q.push_back(wr_data);
                m_cnt = m_cnt + int'(m_acc) - int'(m_pop);
            end
        end
    end

    // Per-cycle comparison on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            chk("status", {22'd0, tx, tx_busy, tx_done, full, empty, overflow, fifo_count}, status_exp());
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (rand_baud) baud = 3'($urandom_range(7, 4));
        end
    endtask

    task automatic put(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        tick(1);
        wr_en   = 1'b0;
    endtask

    logic [2:0] sw_baud [3] = '{3'd1, 3'd2, 3'd7};

    initial begin
        int w;
        int g;
        int d;
        tick(3);
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_count", 32'(fifo_count), 32'd0);
        rst = 1'b0;
        tick(20);
        chk("idle_tx", 32'(tx), 32'd1);
        chk("idle_busy", 32'(tx_busy), 32'd0);

        // First frame at 57600; Baud_Set then changes mid-frame.
        baud = 3'd3;
        put(8'h69);
        w = cyc;
        tick(1);
        chk("first_pre", 32'(tx), 32'd1);
        tick(1);
        chk("first_start", 32'(tx), 32'd0);
        chk("first_busy", 32'(tx_busy), 32'd1);
        rand_baud = 1'b1;
        tick(100);

        for (int i = 0; i < 8; i++) put(8'(i));
        chk("burst_full", 32'(full), 32'd1);
        chk("burst_count", 32'(fifo_count), 32'd8);
        put(8'hFF);
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("ovf_count", 32'(fifo_count), 32'd8);

        // Paced writes keep the FIFO around half full so both pointers wrap twice.
        for (int n = 0; n < 7; n++) begin
            g = 0;
            while ((m_cnt >= 4) && (g < 60000)) begin
                tick(1);
                g++;
            end
            chk("pace_room", 32'(m_cnt < 4), 32'd1);
            put(8'($urandom));
        end
        g = 0;
        while (((m_cnt != 0) || (cyc < m_next_pop + 2)) && (g < 60000)) begin
            tick(1);
            g++;
        end
        chk("drain_empty", 32'(empty), 32'd1);
        chk("drain_idle", 32'(tx_busy), 32'd0);
        chk("ovf_sticky", 32'(overflow), 32'd1);

        // Reset in the data phase of a 9600-baud frame with three bytes queued.
        rand_baud = 1'b0;
        baud = 3'd0;
        put(8'h3C);
        w = cyc;
        for (int i = 0; i < 3; i++) put(8'($urandom));
        tick(w + 2 + 5208 + 700 - cyc);
        chk("mid_busy", 32'(tx_busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_async_tx", 32'(tx), 32'd1);
        chk("rst_async_empty", 32'(empty), 32'd1);
        chk("rst_async_busy", 32'(tx_busy), 32'd0);
        tick(2);
        rst = 1'b0;
        tick(300);
        chk("post_rst_tx", 32'(tx), 32'd1);
        chk("post_rst_empty", 32'(empty), 32'd1);
        chk("post_rst_ovf", 32'(overflow), 32'd0);

        // Start-bit length at the remaining rates, including an out-of-range select.
        for (int b = 0; b < 3; b++) begin
            baud = sw_baud[b];
            d    = exp_div(sw_baud[b]);
            put((sw_baud[b] == 3'd7) ? 8'hA5 : (8'($urandom) | 8'h01));
            tick(1 + d);
            chk("start_last", 32'(tx), 32'd0);
            tick(1);
            chk("bit0_first", 32'(tx), 32'd1);
            tick(40);
            rst = 1'b1;
            tick(2);
            rst = 1'b0;
            tick(5);
        end

        tick(10);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter: CLK_FREQ, 50_000_000, system clock frequency in Hz; the divisor table in REQ-013 is valid for this value only.
REQ-002 Parameter: FIFO_DEPTH, 8, transmit FIFO entries; power of two, 2..64.
REQ-003 Port: clk  input  1  system clock; all logic on rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-high reset; one clock; reset is asynchronous and active-high.
REQ-005 Port: Baud_Set  input  3  baud select (0:9600, 1:19200, 2:38400, 3:57600, 4:115200).
REQ-006 Port: wr_en  input  1  write strobe; pushes wr_data when not full.
REQ-007 Port: wr_data  input  8  byte to transmit.
REQ-008 Port: full  output  1  FIFO holds FIFO_DEPTH entries.
REQ-009 Port: empty  output  1  FIFO holds 0 entries.
REQ-010 Port: fifo_count  output  clog2(FIFO_DEPTH)+1  current occupancy.
REQ-011 Port: overflow  output  1  sticky; set by a rejected write.
REQ-012 Port: tx  output  1  serial line, idle high; tx_busy output 1 (frame in progress); tx_done output 1 (one-cycle end-of-frame pulse).

Function
REQ-013 Bit period SHALL be exactly DIV clk cycles, DIV = 5208/2604/1302/868/434 for Baud_Set 0..4; Baud_Set 5..7 SHALL select 434.
REQ-014 Baud_Set SHALL be sampled once per frame, in the cycle the byte is popped; changes mid-frame SHALL NOT affect that frame.
REQ-015 Frame SHALL be 8N1: start bit 0, data bits LSB first, one stop bit 1; 10*DIV cycles total.
REQ-016 FSM states IDLE, START, DATA, STOP; IDLE->START when FIFO not empty (pop same cycle); START->DATA after DIV cycles; DATA->STOP after 8*DIV cycles; STOP->IDLE after DIV cycles.
REQ-017 At the end of STOP, if FIFO not empty, FSM SHALL pop and enter START in the next cycle with no idle gap beyond that one cycle.
REQ-018 With FSM idle and FIFO empty, tx SHALL go low exactly 2 cycles after the edge sampling wr_en=1.
REQ-019 tx SHALL be driven from a register (glitch-free); tx_busy SHALL be 1 in START, DATA and STOP, 0 in IDLE.
REQ-020 tx_done SHALL pulse high for exactly one cycle, in the last cycle of the stop bit.
REQ-021 Write with full=1 SHALL be discarded and set overflow, even if a pop occurs in the same cycle; full is evaluated before the pop.
REQ-022 Simultaneous write and pop with FIFO neither full nor empty SHALL leave fifo_count unchanged and keep order.
REQ-023 Write to an empty FIFO while IDLE SHALL NOT be popped in the same cycle (no bypass); data leaves strictly FIFO order.
REQ-024 Read/write pointers SHALL wrap modulo FIFO_DEPTH; fifo_count SHALL be exact across wrap.
REQ-025 full, empty, fifo_count SHALL update in the cycle after the causing edge (registered).

Reset
REQ-026 While rst=1: tx=1, tx_busy=0, tx_done=0, empty=1, full=0, fifo_count=0, overflow=0, FSM=IDLE, pointers=0.
REQ-027 Assertion mid-frame SHALL force tx=1 immediately (asynchronously) and discard the frame and all FIFO contents.
REQ-028 After rst deasserts, no frame SHALL start until a new write occurs; overflow clears only on reset.

Verification
REQ-029 Baud_Set=4, write 0x69 once -> tx low 2 cycles later, bits 1,0,0,1,0,1,1,0 at 434-cycle spacing, stop high; tx_done one pulse at cycle 4340 after start.
REQ-030 Burst write 0x00..0x07 (8 bytes) -> full=1 after 8th write (FIFO_DEPTH=8); 9th write 0xFF dropped, overflow=1; 8 frames back-to-back in order, 0xFF never sent.
REQ-031 Baud_Set=0 then changed to 2 mid-frame -> current frame 52080 cycles; next frame 13020 cycles.
REQ-032 Baud_Set=7, write 0xA5 -> bit period 434 cycles.
REQ-033 rst pulse during DATA of byte 0x3C with 3 bytes queued -> tx=1 same cycle, empty=1, no further frames after release.
REQ-034 Write 20 bytes paced to keep FIFO half-full -> pointers wrap twice, all 20 bytes received in order, fifo_count matches scoreboard every cycle.
